// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding a UART transceiver: buffers CSR pushes and issues one byte per frame.
// Latency: push into empty idle FIFO -> level after 1 edge, tx_wr pulse after 2 edges; next byte 2 cycles after tx_done.
// Backpressure: pushes while full are dropped and flagged in sticky overflow; draining waits on tx_done and tx_en.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    input  logic          tx_en,
    input  logic          ovf_clr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [7:0]    tx_data,
    output logic          tx_wr,
    input  logic          tx_done,
    output logic          tx_empty_irq
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_t;

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_full;
    logic          r_empty;
    logic          r_overflow;
    state_t        r_state;
    logic [7:0]    r_tx_data;
    logic          r_tx_wr;
    logic          r_irq;

    logic          w_push;
    logic          w_pop;
    logic          w_ovf_set;
    logic [AW:0]   w_level_nxt;

    // A flush cancels both the push and the pop of its cycle; full gates push on the registered flag,
    // so a push that coincides with a pop from a full queue is still rejected.
    assign w_push    = wr_en && !r_full && !flush;
    assign w_ovf_set = wr_en &&  r_full && !flush;
    assign w_pop     = (r_state == S_IDLE) && tx_en && !r_empty && !flush;

    // Next occupancy: flush empties the queue, otherwise push and pop cancel out.
    always_comb begin
        w_level_nxt = r_level;
        if (flush) begin
            w_level_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + LVL_ONE;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - LVL_ONE;
        end
    end

    // Byte storage; contents are don't-care until written, so no reset.
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered full/empty flags derived from it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_FULL);
            r_empty <= (w_level_nxt == '0);
        end
    end

    // Sticky overflow: a dropped push sets it and wins over a same-cycle clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Issue FSM: pop and pulse tx_wr from IDLE, one ISSUE cycle, then wait in BUSY for the stop bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= S_IDLE;
            r_tx_data <= 8'h00;
            r_tx_wr   <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_tx_wr <= 1'b0;
            r_irq   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= r_mem[r_rd_ptr];
                        r_tx_wr   <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    if (tx_done) begin
                        r_state <= S_IDLE;
                        // Only the byte that drains the queue raises the interrupt; a push
                        // landing on the same edge means more traffic is already pending.
                        r_irq   <= (r_level == '0) && !w_push;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign full         = r_full;
    assign empty        = r_empty;
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign tx_data      = r_tx_data;
    assign tx_wr        = r_tx_wr;
    assign tx_empty_irq = r_irq;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model checked every cycle, plus directed scenarios.
// Inputs change on the falling edge; model updates on the rising edge; outputs compared 2 time units later.
// Transceiver is emulated by pulsing tx_done a chosen number of cycles after each tx_wr.
module tb_uart_tx_fifo;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       tx_en;
    logic       ovf_clr;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_done;
    logic       tx_empty_irq;

    always #5 sys_clk = ~sys_clk;

    uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .flush        (flush),
        .tx_en        (tx_en),
        .ovf_clr      (ovf_clr),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .tx_data      (tx_data),
        .tx_wr        (tx_wr),
        .tx_done      (tx_done),
        .tx_empty_irq (tx_empty_irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The queue holds bytes waiting to be sent; in_flight covers a byte from its tx_wr until tx_done,
    // with fresh marking the first cycle after issue when tx_done is not yet honoured.
    logic [7:0] m_q[$];
    logic       m_ovf;
    logic       m_tx_wr;
    logic [7:0] m_tx_data;
    logic       m_irq;
    bit         m_in_flight;
    bit         m_fresh;
    int         m_sz;
    bit         m_push;
    bit         m_pop;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_q.delete();
            m_ovf       = 1'b0;
            m_tx_wr     = 1'b0;
            m_tx_data   = 8'h00;
            m_irq       = 1'b0;
            m_in_flight = 1'b0;
            m_fresh     = 1'b0;
        end else begin
            m_sz   = m_q.size();
            m_push = wr_en && (m_sz < 16) && !flush;
            m_pop  = !m_in_flight && tx_en && (m_sz > 0) && !flush;
            m_irq  = m_in_flight && !m_fresh && tx_done && (m_sz == 0) && !m_push;
            if (wr_en && (m_sz == 16) && !flush) m_ovf = 1'b1;
            else if (ovf_clr)                    m_ovf = 1'b0;
            m_tx_wr = m_pop;
            if (m_pop) m_tx_data = m_q.pop_front();
            if (flush) m_q.delete();
            if (m_push) m_q.push_back(wr_data);
            if (m_pop) begin
                m_in_flight = 1'b1;
                m_fresh     = 1'b1;
            end else if (m_fresh) begin
                m_fresh = 1'b0;
            end else if (m_in_flight && tx_done) begin
                m_in_flight = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [7:0] got[$];

    always @(posedge sys_clk) begin
        #2;
        check("level",    level,        m_q.size());
        check("full",     full,         m_q.size() == 16);
        check("empty",    empty,        m_q.size() == 0);
        check("overflow", overflow,     m_ovf);
        check("tx_wr",    tx_wr,        m_tx_wr);
        check("tx_data",  tx_data,      m_tx_data);
        check("irq",      tx_empty_irq, m_irq);
        if (tx_wr === 1'b1) got.push_back(tx_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge sys_clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic wait_txwr();
        int g;
        g = 0;
        while (tx_wr !== 1'b1 && g < 300) begin
            cyc();
            g++;
        end
        if (tx_wr !== 1'b1) check("tx_wr_timeout", 0, 1);
    endtask

    task automatic do_done(input int d);
        repeat (d) cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
    endtask

    logic [7:0] sent[$];

    initial begin
        sys_rst_n = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        flush     = 1'b0;
        tx_en     = 1'b0;
        ovf_clr   = 1'b0;
        tx_done   = 1'b0;
        repeat (2) cyc();
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full",  full,  0);
        check("rst_txwr",  tx_wr, 0);
        check("rst_data",  tx_data, 8'h00);
        check("rst_ovf",   overflow, 0);
        check("rst_irq",   tx_empty_irq, 0);
        sys_rst_n = 1'b1;
        cyc();

        // 1: single byte, irq one cycle after tx_done
        got.delete();
        tx_en = 1'b1;
        push_byte(8'h55);
        check("t1_level1", level, 1);
        wait_txwr();
        check("t1_data", tx_data, 8'h55);
        check("t1_level0", level, 0);
        do_done(100);
        check("t1_irq_hi", tx_empty_irq, 1);
        cyc();
        check("t1_irq_lo", tx_empty_irq, 0);
        check("t1_count", got.size(), 1);

        // 2: fill to full, overflow, clear, drain in order
        got.delete();
        tx_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            cyc();
        end
        wr_en = 1'b0;
        check("t2_full", full, 1);
        check("t2_level", level, 16);
        push_byte(8'hAA);
        check("t2_ovf", overflow, 1);
        check("t2_level_kept", level, 16);
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        check("t2_ovf_clr", overflow, 0);
        tx_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_txwr();
            do_done(3);
        end
        check("t2_irq", tx_empty_irq, 1);
        check("t2_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) check("t2_order", got[i], i);

        // 3: 40 bytes through the wrapping pointers with random transceiver delays
        got.delete();
        sent.delete();
        cyc();
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int g;
                    g = 0;
                    while (full === 1'b1 && g < 5000) begin
                        cyc();
                        g++;
                    end
                    sent.push_back(8'((i * 7 + 3) & 8'hFF));
                    push_byte(8'((i * 7 + 3) & 8'hFF));
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    wait_txwr();
                    do_done($urandom_range(1, 50));
                end
            end
        join
        check("t3_count", got.size(), 40);
        for (int i = 0; i < 40 && i < got.size(); i++) check("t3_order", got[i], sent[i]);

        // 4: flush with five queued and one in flight
        got.delete();
        push_byte(8'hC1);
        wait_txwr();
        for (int i = 0; i < 5; i++) push_byte(8'hD0 + 8'(i));
        check("t4_level5", level, 5);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("t4_level0", level, 0);
        check("t4_empty", empty, 1);
        do_done(4);
        check("t4_irq", tx_empty_irq, 1);
        repeat (20) cyc();
        check("t4_count", got.size(), 1);

        // 5: push while full coincides with a pop
        tx_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h80 + 8'(i);
            cyc();
        end
        tx_en   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        cyc();
        wr_en = 1'b0;
        tx_en = 1'b0;
        check("t5_level15", level, 15);
        check("t5_ovf", overflow, 1);
        check("t5_txwr", tx_wr, 1);
        check("t5_data", tx_data, 8'h80);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        do_done(2);

        // 6: asynchronous reset while busy with three queued
        got.delete();
        tx_en = 1'b1;
        for (int i = 0; i < 4; i++) push_byte(8'h11 + 8'(i));
        repeat (3) cyc();
        check("t6_level3", level, 3);
        check("t6_data_pre", tx_data, 8'h11);
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check("t6_rst_level", level, 0);
        check("t6_rst_empty", empty, 1);
        check("t6_rst_ovf",   overflow, 0);
        check("t6_rst_data",  tx_data, 8'h00);
        check("t6_rst_txwr",  tx_wr, 0);
        check("t6_rst_irq",   tx_empty_irq, 0);
        cyc();
        sys_rst_n = 1'b1;
        got.delete();
        repeat (20) cyc();
        check("t6_quiet", got.size(), 0);
        push_byte(8'h77);
        wait_txwr();
        check("t6_new_data", tx_data, 8'h77);
        do_done(1);
        check("t6_irq", tx_empty_irq, 1);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
